// File: rtl/datapath_ctrl_pkg.sv
// Shared datapath definitions: default word size, instruction field
// positions and the controller state encoding.
package datapath_ctrl_pkg;

    localparam int DP_WORD_SIZE = 32;
    localparam int INSTR_W      = 9;

    // Instruction fields: [8:6] alu op, [5:4] addr1, [3:2] addr2, [1:0] addr3
    localparam int ALU_MSB = 8;
    localparam int ALU_LSB = 6;
    localparam int A1_MSB  = 5;
    localparam int A1_LSB  = 4;
    localparam int A2_MSB  = 3;
    localparam int A2_LSB  = 2;
    localparam int A3_MSB  = 1;
    localparam int A3_LSB  = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/datapath_ctrl.sv
// Instruction sequencer for a small register-file/ALU datapath.
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | instr_ready=1, waiting for instr_valid
// ST_SETUP | latched fields on alu/addr*, wr=0, wait counter loaded
// ST_WAIT  | ALU settling for EXEC_CYCLES cycles
// ST_WRITE | wr=1 for one cycle; result/carry captured on exit
// ST_DONE  | done=1 for one cycle; op_count bumped on exit
module datapath_ctrl
    import datapath_ctrl_pkg::*;
#(
    parameter int WORD_SIZE   = DP_WORD_SIZE,
    parameter int EXEC_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [INSTR_W-1:0]   instr,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    output logic [1:0]           addr1,
    output logic [1:0]           addr2,
    output logic [1:0]           addr3,
    output logic [2:0]           alu,
    output logic                 wr,
    input  logic [WORD_SIZE-1:0] result_in,
    input  logic                 cout_in,
    output logic [WORD_SIZE-1:0] res_out,
    output logic                 cout_out,
    output logic                 done,
    output logic [7:0]           op_count
);

    // The counter counts EXEC_CYCLES-1 down to 0, so WAIT spans EXEC_CYCLES cycles.
    localparam logic [3:0] WAIT_LOAD = 4'(EXEC_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] wait_cnt;
    logic       accept;

    assign accept = (state == ST_IDLE) && instr_valid;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and state-decoded strobes.
    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        wr          = 1'b0;
        done        = 1'b0;
        case (state)
            ST_IDLE: begin
                // Held low during reset even though the state already reads IDLE.
                instr_ready = ~rst;
                if (instr_valid) begin
                    state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                wr        = 1'b1;
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Instruction field latch; fields hold until the next accepted instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu   <= 3'd0;
            addr1 <= 2'd0;
            addr2 <= 2'd0;
            addr3 <= 2'd0;
        end else if (accept) begin
            alu   <= instr[ALU_MSB:ALU_LSB];
            addr1 <= instr[A1_MSB:A1_LSB];
            addr2 <= instr[A2_MSB:A2_LSB];
            addr3 <= instr[A3_MSB:A3_LSB];
        end
    end

    // Settle-time down-counter, loaded in SETUP and decremented through WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 4'd0;
        end else if (state == ST_SETUP) begin
            wait_cnt <= WAIT_LOAD;
        end else if ((state == ST_WAIT) && (wait_cnt != 4'd0)) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Result capture on the edge leaving WRITE, so the value is the pre-write one
    // even when the destination aliases a source register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_out  <= '0;
            cout_out <= 1'b0;
        end else if (state == ST_WRITE) begin
            res_out  <= result_in;
            cout_out <= cout_in;
        end
    end

    // Completed-instruction counter, wraps naturally at 256.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count <= 8'd0;
        end else if (state == ST_DONE) begin
            op_count <= op_count + 8'd1;
        end
    end

endmodule

// File: doc/datapath_ctrl.md
DATAPATH_CTRL -- requirements
Module: datapath_ctrl

Interface
REQ-001 The block SHALL have parameter WORD_SIZE, default 32, meaning the width of the datapath result word.
REQ-002 The block SHALL have parameter EXEC_CYCLES, default 1, range 1..15, meaning the number of cycles the ALU result is allowed to settle before write-back.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, the reset: asynchronous and active-high.
REQ-005 The block SHALL have port instr, input, 9, the instruction: [8:6] alu op, [5:4] addr1, [3:2] addr2, [1:0] addr3.
REQ-006 The block SHALL have port instr_valid, input, 1, meaning the instruction is offered.
REQ-007 The block SHALL have port instr_ready, output, 1, meaning the controller can accept an instruction.
REQ-008 The block SHALL have ports addr1 and addr2, output, 2 each, the datapath read addresses.
REQ-009 The block SHALL have port addr3, output, 2, the datapath write address.
REQ-010 The block SHALL have port alu, output, 3, the datapath ALU op.
REQ-011 The block SHALL have port wr, output, 1, the datapath register-file write enable.
REQ-012 The block SHALL have ports result_in, input, WORD_SIZE, and cout_in, input, 1, which carry the datapath result and carry.
REQ-013 The block SHALL have ports res_out, output, WORD_SIZE, and cout_out, output, 1, which carry the captured result and carry.
REQ-014 The block SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-015 The block SHALL have port op_count, output, 8, the count of completed instructions.

Function
REQ-016 The FSM SHALL have states IDLE, SETUP, WAIT, WRITE and DONE, all registered.
REQ-017 instr_ready SHALL be 1 only in IDLE and 0 in all other states.
REQ-018 The handshake SHALL complete on an edge with instr_valid=1 and instr_ready=1; the instruction is latched and the FSM moves to SETUP.
REQ-019 In SETUP the block SHALL drive alu, addr1, addr2 and addr3 from the latched instruction with wr=0, then move to WAIT.
REQ-020 WAIT SHALL last exactly EXEC_CYCLES cycles, tracked by a 4-bit down-counter, then move to WRITE.
REQ-021 In WRITE wr SHALL be 1 for exactly one cycle.
REQ-022 On the edge leaving WRITE, result_in and cout_in SHALL be captured into res_out and cout_out; this is the pre-write value even when addr3 equals addr1 or addr2.
REQ-023 In DONE the block SHALL drive done=1 for one cycle and increment op_count modulo 256 (255 wraps to 0), then return to IDLE.
REQ-024 Latency SHALL be fixed: with the acceptance edge as E0, wr is high between E(1+EXEC_CYCLES) and E(2+EXEC_CYCLES), done follows one cycle later, and instr_ready returns 2 cycles after wr.
REQ-025 alu, addr1, addr2 and addr3 SHALL stay stable from SETUP through WRITE, and SHALL hold their last values in DONE and IDLE.
REQ-026 Changes on instr or instr_valid outside IDLE SHALL have no effect; there is no queueing.
REQ-027 With instr_valid held at 1, back-to-back instructions SHALL be accepted on the first IDLE edge, one every 4+EXEC_CYCLES cycles.
REQ-028 All 8 alu codes SHALL be passed through unmodified; no opcode is illegal.

Reset
REQ-029 rst=1 SHALL immediately, asynchronously force: state IDLE, wr=0, done=0, and zero on addr1, addr2, addr3, alu, res_out, cout_out, op_count and the wait counter.
REQ-030 instr_ready SHALL be 0 while rst=1 and 1 on the first cycle after release.
REQ-031 Reset in any state, including mid-WAIT or in WRITE, SHALL abort the instruction with no capture and no op_count increment.

Structure
REQ-032 State encodings, instruction field positions and WORD_SIZE SHALL live in the shared datapath definitions include file, alongside the datapath.
REQ-033 The block SHALL be a single module with no sub-modules; the wait counter is inline.

Verification
REQ-034 The bench SHALL cover reset: rst=1 mid-run -> wr=0, res_out=0, op_count=0 at once; instr_ready=1 one cycle after release.
REQ-035 The bench SHALL cover a single op: instr=9'b001_01_01_01 accepted at E0, result_in=32'h5 -> alu=001, addr*=01 from SETUP; wr high E2-E3; res_out=32'h5; done at E3-E4; op_count=1.
REQ-036 The bench SHALL cover back-to-back ops: instr_valid held 1 with 9'b010_10_10_00 then 9'b000_00_11_11 -> accepts 5 cycles apart, two wr pulses, op_count=2.
REQ-037 The bench SHALL cover busy-time noise: instr changed and instr_valid toggled during WAIT -> outputs unchanged, no extra accept.
REQ-038 The bench SHALL cover abort: rst asserted during WAIT with EXEC_CYCLES=3 -> wr never asserts, done never pulses, state IDLE.
REQ-039 The bench SHALL cover wrap and carry: 256 ops -> op_count=0; op with cout_in=1, result_in=32'hFFFF_FFFF -> cout_out=1, res_out=32'hFFFF_FFFF.
